// File: rtl/uart_tx_engine.sv
// UART transmit engine: circular TX FIFO feeding a start/data/parity/stop serializer.
// Frame settings are captured when a byte is popped and stay fixed until the frame ends.
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [14:0]      uart_control,
    input  logic             tx_fifo_wr,
    input  logic [7:0]       tx_fifo_data_in,
    output logic             uart_tx,
    output logic             tx_fifo_full,
    output logic             tx_fifo_empty,
    output logic             tx_busy,
    output logic             tx_overflow,
    output logic [CNT_W-1:0] tx_fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic parity_bit(input logic [7:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic             push, pop;

    state_t           state_q, state_d;
    logic [11:0]      baud_q, baud_d, div_q, div_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic             tx_q, tx_d, busy_q, busy_d;

    always_comb begin
        push       = tx_fifo_wr && !full_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d     = (count_d == CNT_FULL);
        empty_d    = (count_d == '0);
        // A push against a full FIFO is lost even when a pop frees a slot this cycle.
        overflow_d = overflow_q | (tx_fifo_wr & full_q);
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (uart_control[12] && !empty_q) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    div_d     = uart_control[11:0];
                    baud_d    = uart_control[11:0];
                    par_en_d  = uart_control[13];
                    par_odd_d = uart_control[14];
                    state_d   = START;
                end
            end
            START: begin
                if (baud_q == 12'd0) begin
                    baud_d    = div_q;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - 12'd1;
                end
            end
            DATA: begin
                if (baud_q == 12'd0) begin
                    baud_d = div_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 12'd1;
                end
            end
            PARITY: begin
                if (baud_q == 12'd0) begin
                    baud_d  = div_q;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q - 12'd1;
                end
            end
            STOP: begin
                if (baud_q == 12'd0) begin
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q - 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line register follows the next state so it lines up with state_q.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_idx_d];
            PARITY:  tx_d = parity_bit(shift_d, par_odd_d);
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_fifo_data_in;
        end
        shift_q   <= shift_d;
        div_q     <= div_d;
        par_en_q  <= par_en_d;
        par_odd_q <= par_odd_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign uart_tx       = tx_q;
    assign tx_fifo_full  = full_q;
    assign tx_fifo_empty = empty_q;
    assign tx_busy       = busy_q;
    assign tx_overflow   = overflow_q;
    assign tx_fifo_count = count_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: framing, parity, FIFO full/overflow, ordering, reset abort.
module tb_uart_tx_engine;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] uart_control = '0;
    logic        tx_fifo_wr = 1'b0;
    logic [7:0]  tx_fifo_data_in = '0;
    logic        uart_tx, tx_fifo_full, tx_fifo_empty, tx_busy, tx_overflow;
    logic [3:0]  tx_fifo_count;

    int total = 0;
    int bad   = 0;

    uart_tx_engine #(.FIFO_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .uart_control(uart_control),
        .tx_fifo_wr(tx_fifo_wr), .tx_fifo_data_in(tx_fifo_data_in),
        .uart_tx(uart_tx), .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
        .tx_busy(tx_busy), .tx_overflow(tx_overflow), .tx_fifo_count(tx_fifo_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ctrl(input int div, input logic en, input logic pen,
                                         input logic podd);
        logic [11:0] d;
        d = 12'(div);
        return {podd, pen, en, d};
    endfunction

    task automatic push(input logic [7:0] b);
        tx_fifo_wr      = 1'b1;
        tx_fifo_data_in = b;
        tick();
        tx_fifo_wr      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Called at the sample just after the pop edge; returns at the sample after the STOP bit.
    task automatic check_frame(input string tag, input logic [7:0] b, input int div,
                               input logic pen, input logic podd);
        logic bits [11];
        int   n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        n = 9;
        if (pen) begin
            bits[n] = (^b) ^ podd;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k <= div; k++) begin
                chk_b($sformatf("%s tx bit%0d clk%0d", tag, i, k), uart_tx, bits[i]);
                chk_b($sformatf("%s busy bit%0d clk%0d", tag, i, k), tx_busy, 1'b1);
                tick();
            end
        end
        chk_b({tag, " idle tx"}, uart_tx, 1'b1);
        chk_b({tag, " idle busy"}, tx_busy, 1'b0);
    endtask

    logic [7:0] vals [8];

    initial begin
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        // Reset state
        tick();
        tick();
        chk_b("rst tx", uart_tx, 1'b1);
        chk_b("rst empty", tx_fifo_empty, 1'b1);
        chk_b("rst full", tx_fifo_full, 1'b0);
        chk_b("rst busy", tx_busy, 1'b0);
        chk_b("rst ovf", tx_overflow, 1'b0);
        chk_c("rst count", tx_fifo_count, 4'd0);
        reset = 1'b1;

        // Single frame, DIV=3, no parity
        uart_control = ctrl(3, 1'b1, 1'b0, 1'b0);
        push(8'hA5);
        chk_c("single count after push", tx_fifo_count, 4'd1);
        chk_b("single empty after push", tx_fifo_empty, 1'b0);
        chk_b("single busy before pop", tx_busy, 1'b0);
        chk_b("single tx before pop", uart_tx, 1'b1);
        tick();
        chk_c("single count after pop", tx_fifo_count, 4'd0);
        chk_b("single empty after pop", tx_fifo_empty, 1'b1);
        check_frame("single", 8'hA5, 3, 1'b0, 1'b0);

        // Parity even then odd; enable dropped mid-frame; control change applies next frame
        uart_control = ctrl(0, 1'b0, 1'b1, 1'b0);
        push(8'h07);
        push(8'h07);
        uart_control = ctrl(0, 1'b1, 1'b1, 1'b0);
        tick();
        uart_control = ctrl(0, 1'b0, 1'b1, 1'b1);
        check_frame("par even", 8'h07, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_b("en off busy", tx_busy, 1'b0);
            chk_c("en off count", tx_fifo_count, 4'd1);
        end
        uart_control = ctrl(0, 1'b1, 1'b1, 1'b1);
        tick();
        check_frame("par odd", 8'h07, 0, 1'b1, 1'b1);

        // Fill, overflow, then release in order with one idle clock between frames
        uart_control = ctrl(1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push(vals[i]);
        chk_c("fill count", tx_fifo_count, 4'd8);
        chk_b("fill full", tx_fifo_full, 1'b1);
        chk_b("fill ovf", tx_overflow, 1'b0);
        push(8'h99);
        chk_b("ovf set", tx_overflow, 1'b1);
        chk_c("ovf count", tx_fifo_count, 4'd8);
        chk_b("ovf full", tx_fifo_full, 1'b1);
        uart_control = ctrl(1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_c($sformatf("release count %0d", i), tx_fifo_count, 4'(7 - i));
            chk_b($sformatf("release full %0d", i), tx_fifo_full, 1'b0);
            check_frame($sformatf("release %0d", i), vals[i], 1, 1'b0, 1'b0);
        end
        chk_b("release empty", tx_fifo_empty, 1'b1);
        chk_b("release ovf sticky", tx_overflow, 1'b1);

        // Push while full during a pop: dropped, overflow set
        do_reset();
        chk_b("rst2 ovf cleared", tx_overflow, 1'b0);
        uart_control = ctrl(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push(vals[i]);
        uart_control = ctrl(0, 1'b1, 1'b0, 1'b0);
        push(8'hEE);
        chk_c("full+pop count", tx_fifo_count, 4'd7);
        chk_b("full+pop ovf", tx_overflow, 1'b1);
        chk_b("full+pop full", tx_fifo_full, 1'b0);

        // Push at count 3 during a pop: count unchanged
        do_reset();
        uart_control = ctrl(0, 1'b0, 1'b0, 1'b0);
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        chk_c("cnt3 before", tx_fifo_count, 4'd3);
        uart_control = ctrl(0, 1'b1, 1'b0, 1'b0);
        push(8'hD4);
        uart_control = ctrl(0, 1'b0, 1'b0, 1'b0);
        chk_c("cnt3 push+pop", tx_fifo_count, 4'd3);
        chk_b("cnt3 ovf", tx_overflow, 1'b0);
        check_frame("cnt3 head", 8'hA1, 0, 1'b0, 1'b0);

        // Reset during DATA bit 4 aborts the frame and discards the FIFO
        do_reset();
        uart_control = ctrl(1, 1'b0, 1'b0, 1'b0);
        push(8'hC3);
        push(8'h77);
        uart_control = ctrl(1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk_b("abort bit4 tx", uart_tx, 1'b0);
        chk_b("abort bit4 busy", tx_busy, 1'b1);
        chk_c("abort bit4 count", tx_fifo_count, 4'd1);
        do_reset();
        chk_b("abort tx", uart_tx, 1'b1);
        chk_b("abort busy", tx_busy, 1'b0);
        chk_c("abort count", tx_fifo_count, 4'd0);
        chk_b("abort empty", tx_fifo_empty, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_b("post abort tx", uart_tx, 1'b1);
            chk_b("post abort busy", tx_busy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default $clog2(FIFO_DEPTH)+1, meaning width of tx_fifo_count.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port uart_control  input  15  control bits: [11:0] baud divisor DIV, [12] tx_enable, [13] parity_en, [14] parity_odd.
REQ-006 SHALL have port tx_fifo_wr  input  1  single-cycle push strobe from the LSU.
REQ-007 SHALL have port tx_fifo_data_in  input  8  byte to push.
REQ-008 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-009 SHALL have port tx_fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 SHALL have port tx_fifo_empty  output  1  FIFO holds 0 entries.
REQ-011 SHALL have port tx_busy  output  1  serializer is in a state other than IDLE.
REQ-012 SHALL have port tx_overflow  output  1  sticky flag: a push was dropped.
REQ-013 SHALL have port tx_fifo_count  output  CNT_W  current FIFO occupancy.

Function
REQ-014 The FIFO SHALL be circular, with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-015 The FIFO SHALL be first-in first-out, and all status outputs SHALL be registered.
REQ-016 When tx_fifo_wr=1 and tx_fifo_full=0, the push SHALL be accepted; count +1 next cycle.
REQ-017 When tx_fifo_wr=1 and tx_fifo_full=1, the push SHALL be dropped and tx_overflow set to 1 next cycle, even if a pop occurs in the same cycle.
REQ-018 tx_overflow SHALL be cleared only by reset.
REQ-019 On a simultaneous accepted push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 A push into an empty FIFO SHALL NOT be popped in the same cycle; it becomes poppable the following cycle.
REQ-021 The serializer FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-022 Bit period SHALL be DIV+1 clocks; DIV=0 gives 1 clock per bit.
REQ-023 DIV, parity_en and parity_odd SHALL be latched at pop and held constant for the whole frame.
REQ-024 IDLE: when tx_enable=1 and tx_fifo_empty=0, the FSM SHALL pop the head byte into the shift register and enter START next cycle; otherwise it stays in IDLE.
REQ-025 START SHALL drive uart_tx=0 for one bit period, then enter DATA.
REQ-026 DATA SHALL send 8 bits LSB first, one bit period each, using a 3-bit bit index.
REQ-027 After bit 7, DATA SHALL enter PARITY if parity_en=1, else STOP.
REQ-028 PARITY SHALL send the XOR of the 8 data bits, inverted when parity_odd=1, for one bit period.
REQ-029 STOP SHALL drive uart_tx=1 for one bit period, then return to IDLE.
REQ-030 Back-to-back frames SHALL therefore have exactly 1 clock of idle-high between the STOP bit and the next START bit.
REQ-031 Deasserting tx_enable mid-frame SHALL NOT abort the frame; no new pop occurs until tx_enable=1 again.
REQ-032 uart_tx SHALL be driven from a register, so there is no combinational path from any input.
REQ-033 Changes to uart_control during a frame SHALL affect only the next frame.

Reset
REQ-034 When reset=0 at a clock edge, the FSM SHALL go to IDLE and both pointers and the count SHALL clear to 0.
REQ-035 After that reset: uart_tx=1, tx_fifo_empty=1, tx_fifo_full=0, tx_busy=0, tx_overflow=0, tx_fifo_count=0.
REQ-036 Reset SHALL take priority over push and pop.
REQ-037 Reset mid-frame SHALL abort the frame and discard FIFO contents; uart_tx=1 the cycle after.

Verification
REQ-038 Single frame: DIV=3, parity off, tx_enable=1; push 0xA5 at cycle 0 -> pop at cycle 1; uart_tx=0 during cycles 2-5; data bits 1,0,1,0,0,1,0,1 at 4 clocks each; stop high for 4 clocks; tx_busy=1 for 40 clocks.
REQ-039 Parity: DIV=0, parity_en=1, parity_odd=0, byte 0x07 -> parity bit 1; same byte with parity_odd=1 -> parity bit 0; frame is 11 clocks.
REQ-040 Full/overflow: tx_enable=0, push 8 bytes -> count=8, full=1; 9th push -> dropped, overflow=1, count stays 8.
REQ-041 FIFO release: from REQ-040, set tx_enable=1 -> all 8 bytes sent in push order; frames separated by exactly 1 idle clock; empty=1 after the last pop.
REQ-042 Simultaneous events: push while full during a pop -> push dropped and overflow set; push while count=3 during a pop -> count stays 3.
REQ-043 Reset mid-frame: reset=0 during DATA bit 4 -> next cycle uart_tx=1, busy=0, count=0; the aborted byte is never resumed.
